// File: rtl/sonar_disp_pkg.sv
// Shared constants, types and helpers for the
// sonar VGA display generator.
package sonar_disp_pkg;

  localparam int CNT_W = 12;
  localparam int POS_W = 10;

  localparam logic [3:0] GRID_MAJ = 4'hF;
  localparam logic [3:0] GRID_MIN = 4'h5;
  localparam logic [3:0] BG       = 4'h1;

  typedef struct packed {
    logic             v;
    logic [POS_W-1:0] p;
  } hist_ent_t;

  function automatic int span_total(
    input int act, input int fp,
    input int sw,  input int bp
  );
    return act + fp + sw + bp;
  endfunction

  function automatic int sync_start(
    input int act, input int fp
  );
    return act + fp;
  endfunction

  function automatic int sync_end(
    input int act, input int fp, input int sw
  );
    return act + fp + sw;
  endfunction

  // {red, green, blue} enables for each channel
  function automatic logic [2:0] ch_mask(input int c);
    logic [2:0] m;
    case (c)
      0:       m = 3'b100;
      1:       m = 3'b001;
      2:       m = 3'b101;
      default: m = 3'b110;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters, grid phase counters and
// sync / active / frame-start decode.
module vga_timing_gen
  import sonar_disp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int GRID     = 78
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] hc,
  output logic             hs_on,
  output logic             vs_on,
  output logic             act,
  output logic             grid_maj,
  output logic             grid_min,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CNT_W-1:0] HS_LO =
    CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_HI =
    CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_LO =
    CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_HI =
    CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));
  localparam logic [CNT_W-1:0] HA = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VA = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GRID - 1);
  localparam logic [CNT_W-1:0] G_HALF = CNT_W'(GRID / 2);

  logic [CNT_W-1:0] vc;
  logic [CNT_W-1:0] hg;
  logic [CNT_W-1:0] vg;

  // raster position plus grid phase, which stands in for hc/vc mod GRID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
      hg <= '0;
      vg <= '0;
    end else if (pix_ce) begin
      if (hc == H_LAST) begin
        hc <= '0;
        hg <= '0;
        if (vc == V_LAST) begin
          vc <= '0;
          vg <= '0;
        end else begin
          vc <= vc + 1'b1;
          vg <= (vg == G_LAST) ? '0 : vg + 1'b1;
        end
      end else begin
        hc <= hc + 1'b1;
        hg <= (hg == G_LAST) ? '0 : hg + 1'b1;
      end
    end
  end

  assign hs_on      = (hc >= HS_LO) && (hc < HS_HI);
  assign vs_on      = (vc >= VS_LO) && (vc < VS_HI);
  assign act        = (hc < HA) && (vc < VA);
  assign grid_maj   = (hg == '0) || (vg == '0);
  assign grid_min   = (hg == G_HALF) || (vg == G_HALF);
  assign frame_tick = pix_ce && (hc == '0) && (vc == '0);

endmodule

// File: rtl/sonar_display_gen.sv
// Sonar VGA raster: range grid plus per-channel
// target traces with fading frame persistence.
module sonar_display_gen
  import sonar_disp_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   GRID     = 78,
  parameter int   N_CH     = 2,
  parameter int   HIST     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_ce,
  input  logic [N_CH*POS_W-1:0] pos_flat,
  input  logic [N_CH-1:0]       pos_valid,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic [3:0]            o_red,
  output logic [3:0]            o_green,
  output logic [3:0]            o_blue,
  output logic                  o_active,
  output logic                  o_frame_start
);

  localparam logic [POS_W-1:0] P_MAX =
    POS_W'(H_ACTIVE - 1);

  logic [CNT_W-1:0] hc;
  logic             hs_on;
  logic             vs_on;
  logic             act;
  logic             grid_maj;
  logic             grid_min;
  logic             frame_tick;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .GRID     (GRID)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_ce     (pix_ce),
    .hc         (hc),
    .hs_on      (hs_on),
    .vs_on      (vs_on),
    .act        (act),
    .grid_maj   (grid_maj),
    .grid_min   (grid_min),
    .frame_tick (frame_tick)
  );

  logic [POS_W-1:0] pos_in   [N_CH];
  logic [POS_W-1:0] pending  [N_CH];
  logic [N_CH-1:0]  pend_v;
  hist_ent_t        hist     [N_CH][HIST];
  hist_ent_t        hist_nxt [N_CH][HIST];

  logic       hit;
  logic [3:0] lvl;
  logic [2:0] msk;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  // split the flat position bus and clamp to the visible width
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      pos_in[c] = pos_flat[c*POS_W +: POS_W];
      if (pos_in[c] > P_MAX) pos_in[c] = P_MAX;
    end
  end

  // history after a shift; a strobe on the shift cycle bypasses pending
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      hist_nxt[c][0] = pos_valid[c]
        ? hist_ent_t'({1'b1, pos_in[c]})
        : hist_ent_t'({pend_v[c], pending[c]});
      for (int k = 1; k < HIST; k++)
        hist_nxt[c][k] = hist[c][k-1];
    end
  end

  // latest position per channel, held until the next frame shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) pending[c] <= '0;
      pend_v <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (pos_valid[c]) pending[c] <= pos_in[c];
      pend_v <= frame_tick ? '0 : (pend_v | pos_valid);
    end
  end

  // persistence buffer, shifted once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++)
        for (int k = 0; k < HIST; k++)
          hist[c][k] <= '0;
    end else if (frame_tick) begin
      for (int c = 0; c < N_CH; c++)
        for (int k = 0; k < HIST; k++)
          hist[c][k] <= hist_nxt[c][k];
    end
  end

  // trace hit search; reverse scan so lowest channel / newest age wins
  always_comb begin
    hist_ent_t ent;
    ent = '0;
    hit = 1'b0;
    lvl = '0;
    msk = '0;
    for (int c = N_CH-1; c >= 0; c--) begin
      for (int k = HIST-1; k >= 0; k--) begin
        ent = frame_tick ? hist_nxt[c][k] : hist[c][k];
        if (ent.v && (CNT_W'(ent.p) == hc)) begin
          hit = 1'b1;
          lvl = 4'hF >> k;
          msk = ch_mask(c);
        end
      end
    end
  end

  // colour select: trace over major grid over minor grid over background
  always_comb begin
    if (hit) begin
      red   = msk[2] ? lvl : '0;
      green = msk[1] ? lvl : '0;
      blue  = msk[0] ? lvl : '0;
    end else begin
      red   = '0;
      blue  = '0;
      green = grid_maj ? GRID_MAJ
            : grid_min ? GRID_MIN
            : BG;
    end
  end

  // output registers, one pixel behind the raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_active      <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= frame_tick;
      if (pix_ce) begin
        o_hsync  <= hs_on ? SYNC_POL : ~SYNC_POL;
        o_vsync  <= vs_on ? SYNC_POL : ~SYNC_POL;
        o_active <= act;
        o_red    <= act ? red   : '0;
        o_green  <= act ? green : '0;
        o_blue   <= act ? blue  : '0;
      end
    end
  end

endmodule

// File: tb/tb_sonar_display_gen.sv
// Self-checking bench for sonar_display_gen with a
// frame-level reference model and random strobes.
module tb_sonar_display_gen;

  localparam int HA = 40;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 4;
  localparam int VA = 16;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int GR = 8;
  localparam int NC = 2;
  localparam int HI = 4;
  localparam logic POL = 1'b0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pix_ce = 1'b0;
  logic [NC*10-1:0] pos_flat = '0;
  logic [NC-1:0] pos_valid = '0;
  logic o_hsync, o_vsync, o_active, o_frame_start;
  logic [3:0] o_red, o_green, o_blue;

  sonar_display_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (POL), .GRID (GR), .N_CH (NC), .HIST (HI)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_ce        (pix_ce),
    .pos_flat      (pos_flat),
    .pos_valid     (pos_valid),
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_red         (o_red),
    .o_green       (o_green),
    .o_blue        (o_blue),
    .o_active      (o_active),
    .o_frame_start (o_frame_start)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {o_hsync, o_vsync, o_red, o_green,
                o_blue, o_active, o_frame_start};

  logic [15:0] expv;
  int cmps = 0;
  int fails = 0;

  int n;
  int pend [NC];
  bit pendv [NC];
  int hp [NC][HI];
  bit hv [NC][HI];
  bit last_ce;
  bit last_latch;
  int last_hc;
  int last_vc;
  logic [11:0] snap [FR];

  function automatic void model_reset();
    n = 0;
    for (int c = 0; c < NC; c++) begin
      pend[c] = 0;
      pendv[c] = 0;
      for (int k = 0; k < HI; k++) begin
        hp[c][k] = 0;
        hv[c][k] = 0;
      end
    end
    expv = {!POL, !POL, 12'h000, 1'b0, 1'b0};
  endfunction

  function automatic logic [15:0] pixel(int x, int y);
    logic [3:0] r, g, b;
    logic hs, vs, act;
    bit found;
    int lvl;
    r = 0; g = 0; b = 0; act = 0; found = 0;
    hs = (x >= HA+HF && x < HA+HF+HS) ? POL : !POL;
    vs = (y >= VA+VF && y < VA+VF+VS) ? POL : !POL;
    if (x < HA && y < VA) begin
      act = 1;
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < HI; k++)
          if (!found && hv[c][k] && hp[c][k] == x) begin
            found = 1;
            lvl = 15 >> k;
            case (c)
              0: r = 4'(lvl);
              1: b = 4'(lvl);
              2: begin r = 4'(lvl); b = 4'(lvl); end
              default: begin r = 4'(lvl); g = 4'(lvl); end
            endcase
          end
      if (!found) begin
        if (x % GR == 0 || y % GR == 0) g = 4'hF;
        else if (x % GR == GR/2 || y % GR == GR/2) g = 4'h5;
        else g = 4'h1;
      end
    end
    return {hs, vs, r, g, b, act, 1'b0};
  endfunction

  task automatic tick();
    bit ce;
    logic [NC-1:0] pv;
    logic [NC*10-1:0] pf;
    int p;
    ce = pix_ce;
    pv = pos_valid;
    pf = pos_flat;
    @(posedge clk);
    last_ce = 0;
    last_latch = 0;
    if (!rst_n) model_reset();
    else begin
      for (int c = 0; c < NC; c++) begin
        p = int'(pf[c*10 +: 10]);
        if (p >= HA) p = HA - 1;
        if (ce && n == 0) begin
          for (int k = HI-1; k > 0; k--) begin
            hp[c][k] = hp[c][k-1];
            hv[c][k] = hv[c][k-1];
          end
          hp[c][0] = pv[c] ? p : pend[c];
          hv[c][0] = pv[c] ? 1'b1 : pendv[c];
          if (pv[c]) pend[c] = p;
          pendv[c] = 0;
        end else if (pv[c]) begin
          pend[c] = p;
          pendv[c] = 1;
        end
      end
      if (ce) begin
        last_ce = 1;
        last_latch = (n == 0);
        last_hc = n % HT;
        last_vc = n / HT;
        expv = pixel(last_hc, last_vc);
        expv[0] = last_latch;
        n = (n + 1) % FR;
      end else expv[0] = 1'b0;
    end
    #1;
    if (last_ce) snap[last_vc*HT + last_hc] = obs[13:2];
    pix_ce = ~pix_ce;
    pos_valid = '0;
  endtask

  task automatic sync_frame();
    int guard;
    guard = 0;
    while (!(pix_ce && n == 0) && guard < 2*FR+4) begin
      tick();
      guard++;
    end
    if (guard >= 2*FR+4) begin
      fails++;
      $display("FAIL sync_frame timeout n=%0d", n);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    cmps++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL reset_async got=%h exp=%h", obs, expv);
    end
    repeat (6) begin
      tick();
      cmps++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL reset_hold got=%h exp=%h", obs, expv);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timing();
    int hs_lo, vs_lo, act_n;
    hs_lo = 0; vs_lo = 0; act_n = 0;
    for (int t = 0; t < 2*FR; t++) begin
      tick();
      cmps++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL timing t=%0d got=%h exp=%h", t, obs, expv);
      end
      if (last_ce) begin
        if (o_hsync == POL) hs_lo++;
        if (o_vsync == POL) vs_lo++;
        if (o_active) act_n++;
      end
    end
    cmps++;
    if (hs_lo != HS*VT) begin
      fails++;
      $display("FAIL hsync_count got=%0d exp=%0d", hs_lo, HS*VT);
    end
    cmps++;
    if (vs_lo != VS*HT) begin
      fails++;
      $display("FAIL vsync_count got=%0d exp=%0d", vs_lo, VS*HT);
    end
    cmps++;
    if (act_n != HA*VA) begin
      fails++;
      $display("FAIL active_count got=%0d exp=%0d", act_n, HA*VA);
    end
    cmps++;
    if (snap[0] !== 12'h0F0) begin
      fails++;
      $display("FAIL grid_major_00 got=%h exp=0f0", snap[0]);
    end
    cmps++;
    if (snap[3*HT+8] !== 12'h0F0) begin
      fails++;
      $display("FAIL grid_major_83 got=%h exp=0f0", snap[3*HT+8]);
    end
    cmps++;
    if (snap[1*HT+4] !== 12'h050) begin
      fails++;
      $display("FAIL grid_minor got=%h exp=050", snap[1*HT+4]);
    end
    cmps++;
    if (snap[1*HT+1] !== 12'h010) begin
      fails++;
      $display("FAIL background got=%h exp=010", snap[1*HT+1]);
    end
    cmps++;
    if (snap[3*HT+45] !== 12'h000 || snap[18*HT+3] !== 12'h000) begin
      fails++;
      $display("FAIL blanking got=%h/%h exp=000",
               snap[3*HT+45], snap[18*HT+3]);
    end
  endtask

  task automatic test_persistence();
    int er [6] = '{0, 15, 7, 3, 1, 0};
    int eg [6] = '{5, 0, 0, 0, 0, 5};
    int f;
    sync_frame();
    for (int t = 0; t < 2*FR*6; t++) begin
      if (t == 100) begin
        pos_flat[9:0] = 10'd20;
        pos_valid[0] = 1'b1;
      end
      tick();
      cmps++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL persist t=%0d got=%h exp=%h", t, obs, expv);
      end
      f = t / (2*FR);
      if (last_ce && last_hc == 20 && last_vc == 5) begin
        cmps++;
        if (o_red !== 4'(er[f]) || o_green !== 4'(eg[f])) begin
          fails++;
          $display("FAIL fade frame=%0d got=%h/%h exp=%h/%h",
                   f, o_red, o_green, er[f], eg[f]);
        end
      end
    end
  endtask

  task automatic test_priority();
    int f;
    sync_frame();
    for (int t = 0; t < 2*FR*3; t++) begin
      if (t == 200) begin
        pos_flat = {10'd30, 10'd30};
        pos_valid = 2'b11;
      end
      if (t == 2*FR + 200) begin
        pos_flat[19:10] = 10'd31;
        pos_valid = 2'b10;
      end
      tick();
      cmps++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL prio t=%0d got=%h exp=%h", t, obs, expv);
      end
    end
    f = 0;
    cmps++;
    if (o_frame_start === 1'bx) f = 1;
    if (f != 0) begin
      fails++;
      $display("FAIL prio_fs got=x exp=known");
    end
  endtask

  task automatic test_priority_pix();
    logic [11:0] a, b2, c2;
    int f;
    sync_frame();
    for (int t = 0; t < 2*FR*3; t++) begin
      if (t == 200) begin
        pos_flat = {10'd30, 10'd30};
        pos_valid = 2'b11;
      end
      if (t == 2*FR + 200) begin
        pos_flat[19:10] = 10'd31;
        pos_valid = 2'b10;
      end
      tick();
      cmps++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL prio_pix t=%0d got=%h exp=%h", t, obs, expv);
      end
      f = t / (2*FR);
      if (last_ce && last_vc == 5) begin
        if (f == 1 && last_hc == 30) a = obs[13:2];
        if (f == 2 && last_hc == 31) b2 = obs[13:2];
        if (f == 2 && last_hc == 30) c2 = obs[13:2];
      end
    end
    cmps++;
    if (a !== 12'hF00) begin
      fails++;
      $display("FAIL ch0_wins got=%h exp=f00", a);
    end
    cmps++;
    if (b2 !== 12'h00F) begin
      fails++;
      $display("FAIL ch1_blue got=%h exp=00f", b2);
    end
    cmps++;
    if (c2 !== 12'h700) begin
      fails++;
      $display("FAIL ch0_age1 got=%h exp=700", c2);
    end
  endtask

  task automatic test_clamp_bypass();
    logic [11:0] c1, b1, b2, c2;
    int f;
    sync_frame();
    for (int t = 0; t < 2*FR*3; t++) begin
      if (t == 300) begin
        pos_flat[9:0] = 10'd900;
        pos_valid[0] = 1'b1;
      end
      if (t == 2*FR) begin
        pos_flat[19:10] = 10'd17;
        pos_valid[1] = 1'b1;
      end
      tick();
      cmps++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL clamp t=%0d got=%h exp=%h", t, obs, expv);
      end
      f = t / (2*FR);
      if (last_ce && last_vc == 5) begin
        if (f == 1 && last_hc == HA-1) c1 = obs[13:2];
        if (f == 1 && last_hc == 17) b1 = obs[13:2];
        if (f == 2 && last_hc == 17) b2 = obs[13:2];
        if (f == 2 && last_hc == HA-1) c2 = obs[13:2];
      end
    end
    cmps++;
    if (c1 !== 12'hF00) begin
      fails++;
      $display("FAIL clamp_edge got=%h exp=f00", c1);
    end
    cmps++;
    if (b1 !== 12'h00F) begin
      fails++;
      $display("FAIL bypass_new got=%h exp=00f", b1);
    end
    cmps++;
    if (b2 !== 12'h007 || c2 !== 12'h700) begin
      fails++;
      $display("FAIL bypass_age got=%h/%h exp=007/700", b2, c2);
    end
  endtask

  task automatic test_random();
    sync_frame();
    for (int t = 0; t < 2*FR*3; t++) begin
      if ($urandom_range(0, 40) == 0 ||
          (t >= FR && t < FR + 24) ||
          (pix_ce && n == 0 && $urandom_range(0, 1) == 1)) begin
        pos_valid = NC'($urandom_range(1, (1 << NC) - 1));
        for (int c = 0; c < NC; c++)
          pos_flat[c*10 +: 10] = ($urandom_range(0, 3) == 0)
            ? 10'($urandom) : 10'($urandom_range(0, HA-1));
      end
      tick();
      cmps++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL random t=%0d got=%h exp=%h", t, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard, traces;
    bit first;
    guard = 0;
    while (n != 10*HT + 5 && guard < 2*FR+4) begin
      tick();
      guard++;
      cmps++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL pre_reset got=%h exp=%h", obs, expv);
      end
    end
    if (guard >= 2*FR+4) begin
      fails++;
      $display("FAIL mid_reset_reach timeout n=%0d", n);
    end
    pos_flat[9:0] = 10'd12;
    pos_valid[0] = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmps++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL mid_reset_async got=%h exp=%h", obs, expv);
    end
    repeat (5) begin
      tick();
      cmps++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL mid_reset_hold got=%h exp=%h", obs, expv);
      end
    end
    rst_n = 1'b1;
    traces = 0;
    first = 1;
    for (int t = 0; t < 2*FR; t++) begin
      tick();
      cmps++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL post_reset t=%0d got=%h exp=%h", t, obs, expv);
      end
      if (last_ce) begin
        if (first) begin
          first = 0;
          cmps++;
          if (o_frame_start !== 1'b1 || o_active !== 1'b1 ||
              o_green !== 4'hF) begin
            fails++;
            $display("FAIL restart_origin got=%b%b%h exp=11f",
                     o_frame_start, o_active, o_green);
          end
        end
        if (o_red != 4'h0 || o_blue != 4'h0) traces++;
      end
    end
    cmps++;
    if (traces != 0) begin
      fails++;
      $display("FAIL first_frame_blank got=%0d exp=0", traces);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_persistence();
    test_priority_pix();
    test_clamp_bypass();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmps, fails);
    $finish;
  end

endmodule
